// File: rtl/spu_env_pkg.sv
// Shared encodings and constants for the SPU ADSR envelope generator.
package spu_env_pkg;

   typedef enum logic [2:0] {
      PH_IDLE    = 3'd0,
      PH_ATTACK  = 3'd1,
      PH_DECAY   = 3'd2,
      PH_SUSTAIN = 3'd3,
      PH_RELEASE = 3'd4
   } phase_e;

   // Step pipeline: FREE accepts a tick, ADDR drives the ROM, DATA writes the level.
   typedef enum logic [1:0] {
      ST_FREE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } step_e;

   localparam logic [30:0] LEVEL_MAX      = 31'h7FFF_FFFF;
   localparam logic [30:0] ATK_EXP_THRESH = 31'h6000_0000;

   // Envelope parameters captured on key_on.
   typedef struct packed {
      logic [6:0] attack_rate;
      logic       attack_exp;
      logic [3:0] decay_rate;
      logic [3:0] sustain_level;
      logic [6:0] sustain_rate;
      logic       sustain_dir;
      logic       sustain_exp;
      logic [4:0] release_rate;
      logic       release_exp;
   } env_params_t;

   // ROM addresses are 7 bits; any wider sum pins to the last entry.
   function automatic logic [6:0] clamp_adrs(input logic [31:0] a);
      return (a > 32'd127) ? 7'd127 : a[6:0];
   endfunction

endpackage

// File: rtl/spu_adsr_env_if.sv
// Increment/decrement ROM port bundle; master = envelope, slave = ROM side.
interface spu_adsr_env_if;
   logic        [6:0]  add_adrs;
   logic               add_read;
   logic        [21:0] add_dout;
   logic        [6:0]  sub_adrs;
   logic               sub_read;
   logic signed [21:0] sub_dout;

   modport master (output add_adrs, add_read, sub_adrs, sub_read,
                   input  add_dout, sub_dout);
   modport slave  (input  add_adrs, add_read, sub_adrs, sub_read,
                   output add_dout, sub_dout);
endinterface

// File: rtl/spu_env_adrs_gen.sv
// Combinational ROM address and port selection for the current phase/level.
module spu_env_adrs_gen
   import spu_env_pkg::*;
#(
   parameter int unsigned ATK_EXP_STEP  = 8,
   parameter logic [6:0]  SUB_OFS_DECAY = 7'h30
) (
   input  phase_e      phase_i,
   input  logic [30:0] level_i,
   input  env_params_t prm_i,
   output logic        use_add_o,
   output logic [6:0]  adrs_o
);

   logic [31:0] exp_ofs;

   // Pick the ROM port and address; louder levels select gentler exponential slopes.
   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      use_add_o = 1'b0;
      adrs_o    = 7'd0;
      exp_ofs   = 32'(3'd7 - level_i[30:28]);
      case (phase_i)
         PH_ATTACK: begin
            use_add_o = 1'b1;
            if (prm_i.attack_exp && (level_i >= ATK_EXP_THRESH))
               adrs_o = clamp_adrs(32'(prm_i.attack_rate) + ATK_EXP_STEP);
            else
               adrs_o = prm_i.attack_rate;
         end
         PH_DECAY: begin
            adrs_o = clamp_adrs(32'(SUB_OFS_DECAY) + 32'({prm_i.decay_rate, 2'b00}) + exp_ofs);
         end
         PH_SUSTAIN: begin
            if (!prm_i.sustain_dir) begin
               use_add_o = 1'b1;
               adrs_o    = prm_i.sustain_rate;
            end else begin
               adrs_o = clamp_adrs(32'(prm_i.sustain_rate) + (prm_i.sustain_exp ? exp_ofs : 32'd0));
            end
         end
         PH_RELEASE: begin
            adrs_o = clamp_adrs(32'({prm_i.release_rate, 2'b00}) + (prm_i.release_exp ? exp_ofs : 32'd0));
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/spu_adsr_env.sv
// ADSR envelope: one ROM-driven level step per accepted sample tick.
module spu_adsr_env
   import spu_env_pkg::*;
#(
   parameter int unsigned ATK_EXP_STEP  = 8,
   parameter logic [6:0]  SUB_OFS_DECAY = 7'h30
) (
   input  logic                   m_clock,
   input  logic                   p_reset,
   input  logic                   key_on,
   input  logic                   key_off,
   input  logic                   sample_tick,
   input  logic [6:0]             attack_rate,
   input  logic                   attack_exp,
   input  logic [3:0]             decay_rate,
   input  logic [3:0]             sustain_level,
   input  logic [6:0]             sustain_rate,
   input  logic                   sustain_dir,
   input  logic                   sustain_exp,
   input  logic [4:0]             release_rate,
   input  logic                   release_exp,
   spu_adsr_env_if.master         rom,
   output logic [15:0]            env_out,
   output logic [2:0]             env_state,
   output logic                   busy,
   output logic                   env_valid,
   output logic                   voice_end
);

   phase_e       phase_q;
   step_e        step_q;
   logic [30:0]  level_q;
   env_params_t  prm_q;
   env_params_t  prm_in;
   logic         use_add_q;
   logic [6:0]   add_adrs_q, sub_adrs_q;
   logic         add_read_q, sub_read_q;
   logic         env_valid_q, voice_end_q;

   logic         gen_use_add;
   logic [6:0]   gen_adrs;

   // One bit beyond 32 so LEVEL_MAX plus the largest increment cannot overflow.
   logic signed [32:0] rom_term, level_sum;
   logic        [30:0] level_d;
   logic        [31:0] sus_thresh;

   assign prm_in = '{attack_rate:   attack_rate,   attack_exp:  attack_exp,
                     decay_rate:    decay_rate,    sustain_level: sustain_level,
                     sustain_rate:  sustain_rate,  sustain_dir: sustain_dir,
                     sustain_exp:   sustain_exp,   release_rate: release_rate,
                     release_exp:   release_exp};

   spu_env_adrs_gen #(
      .ATK_EXP_STEP  (ATK_EXP_STEP),
      .SUB_OFS_DECAY (SUB_OFS_DECAY)
   ) u_adrs_gen (
      .phase_i   (phase_q),
      .level_i   (level_q),
      .prm_i     (prm_q),
      .use_add_o (gen_use_add),
      .adrs_o    (gen_adrs)
   );

   // Apply the ROM delta to the level with clamping to 0..LEVEL_MAX.
   always_comb begin
      rom_term   = use_add_q ? 33'($signed({1'b0, rom.add_dout})) : 33'(rom.sub_dout);
      level_sum  = $signed({2'b00, level_q}) + rom_term;
      sus_thresh = (32'({1'b0, prm_q.sustain_level} + 5'd1) << 27) - 32'd1;
      if (level_sum > $signed({2'b00, LEVEL_MAX}))
         level_d = LEVEL_MAX;
      else if (level_sum < 33'sd0)
         level_d = 31'd0;
      else
         level_d = level_sum[30:0];
   end

   // Phase/step state machine with registered ROM strobes and status pulses.
   always_ff @(posedge m_clock) begin
      if (p_reset) begin
         phase_q     <= PH_IDLE;
         step_q      <= ST_FREE;
         level_q     <= 31'd0;
         prm_q       <= '0;
         use_add_q   <= 1'b0;
         add_adrs_q  <= 7'd0;
         sub_adrs_q  <= 7'd0;
         add_read_q  <= 1'b0;
         sub_read_q  <= 1'b0;
         env_valid_q <= 1'b0;
         voice_end_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from pre-edge values.
         add_read_q  <= 1'b0;
         sub_read_q  <= 1'b0;
         env_valid_q <= 1'b0;
         voice_end_q <= 1'b0;
         if (key_on) begin
            level_q <= 31'd0;
            prm_q   <= prm_in;
            phase_q <= PH_ATTACK;
            step_q  <= ST_FREE;
         end else if (key_off && (phase_q inside {PH_ATTACK, PH_DECAY, PH_SUSTAIN})) begin
            phase_q <= PH_RELEASE;
            step_q  <= ST_FREE;
         end else begin
            case (step_q)
               ST_FREE: begin
                  if (sample_tick && (phase_q != PH_IDLE)) begin
                     step_q    <= ST_ADDR;
                     use_add_q <= gen_use_add;
                     if (gen_use_add) begin
                        add_adrs_q <= gen_adrs;
                        add_read_q <= 1'b1;
                     end else begin
                        sub_adrs_q <= gen_adrs;
                        sub_read_q <= 1'b1;
                     end
                  end
               end
               ST_ADDR: step_q <= ST_DATA;
               ST_DATA: begin
                  step_q      <= ST_FREE;
                  level_q     <= level_d;
                  env_valid_q <= 1'b1;
                  case (phase_q)
                     PH_ATTACK:  if (level_d == LEVEL_MAX) phase_q <= PH_DECAY;
                     PH_DECAY:   if ({1'b0, level_d} <= sus_thresh) phase_q <= PH_SUSTAIN;
                     PH_RELEASE: begin
                        if (level_d == 31'd0) begin
                           phase_q     <= PH_IDLE;
                           voice_end_q <= 1'b1;
                        end
                     end
                     default: ;
                  endcase
               end
               default: step_q <= ST_FREE;
            endcase
         end
      end
   end

   assign rom.add_adrs = add_adrs_q;
   assign rom.add_read = add_read_q;
   assign rom.sub_adrs = sub_adrs_q;
   assign rom.sub_read = sub_read_q;
   assign env_out      = level_q[30:15];
   assign env_state    = phase_q;
   assign busy         = (step_q != ST_FREE);
   assign env_valid    = env_valid_q;
   assign voice_end    = voice_end_q;

endmodule
